modadd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one modular_addition instance among NREQ requesters in the ECPA point-arithmetic datapath. It latches the winning requester's operands and drives the adder's start/reset handshake. It then returns the result with a one-cycle acknowledge to that requester. A watchdog reports adders that never assert done.

---
 rtl/ecpa_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/modadd_arbiter.sv | 141 ++++++++++++++
 tb/tb_modadd_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecpa_pkg.sv
// Shared types and helpers for the ECPA point-arithmetic datapath.
package ecpa_pkg;

  localparam int unsigned W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    GAP
  } arb_state_t;

  // Width of a counter that must be able to hold the value tmo.
  function automatic int unsigned tmo_width(input int unsigned tmo);
    return (tmo == 0) ? 32'd1 : 32'($clog2(tmo + 1));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping.
module rr_arbiter
  import ecpa_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic                    o_grant_valid_c,
  output logic [$clog2(NREQ)-1:0] o_grant_idx_c
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  always_comb begin
    o_grant_valid_c = 1'b0;
    o_grant_idx_c   = '0;
    cand            = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IW'((32'(i_ptr) + off) % NREQ);
      if (!o_grant_valid_c && i_req[cand]) begin
        o_grant_valid_c = 1'b1;
        o_grant_idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/modadd_arbiter.sv
// Shares one modular adder among NREQ requesters: round-robin grant, operand latch,
// start/reset handshake, one-cycle acknowledge and a done watchdog.
module modadd_arbiter
  import ecpa_pkg::*;
#(
  parameter int unsigned W           = W_DEF,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*W-1:0]       i_a,
  input  logic [NREQ*W-1:0]       i_b,
  input  logic [W-1:0]            i_p,
  output logic [NREQ-1:0]         o_ack,
  output logic                    o_err,
  output logic [W-1:0]            o_result,
  output logic [$clog2(NREQ)-1:0] o_grant_id,
  output logic                    o_busy,
  output logic                    o_add_start,
  output logic                    o_add_rst_n,
  output logic [W-1:0]            o_add_a,
  output logic [W-1:0]            o_add_b,
  output logic [W-1:0]            o_add_p,
  input  logic [W-1:0]            i_add_result,
  input  logic                    i_add_done
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = tmo_width(TIMEOUT_CYC);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, p_q, p_d;
  logic [W-1:0]  result_q, result_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic          err_q, err_d;
  logic          busy_q, start_q, lrst_q;

  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req          (i_req),
    .i_ptr          (ptr_q),
    .o_grant_valid_c(gnt_valid),
    .o_grant_idx_c  (gnt_idx)
  );

  // Next-state, operand capture and response generation.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    result_d = result_q;
    ack_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ISSUE;
          gid_d   = gnt_idx;
          a_d     = i_a[32'(gnt_idx)*W +: W];
          b_d     = i_b[32'(gnt_idx)*W +: W];
          p_d     = i_p;
          cnt_d   = '0;
          ptr_d   = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
        end
      end
      ISSUE: begin
        if (i_add_done) begin
          state_d      = RESP;
          result_d     = i_add_result;
          ack_d[gid_q] = 1'b1;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TW'(TIMEOUT_CYC))) begin
          state_d      = RESP;
          result_d     = '0;
          err_d        = 1'b1;
          ack_d[gid_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gid_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      lrst_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      result_q <= result_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
      start_q  <= (state_d == ISSUE);
      lrst_q   <= (state_d != GAP);
    end
  end

  // The adder is held in reset during GAP and whenever the block itself is reset.
  assign o_add_rst_n = i_rst_n & lrst_q;
  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_result    = result_q;
  assign o_grant_id  = gid_q;
  assign o_busy      = busy_q;
  assign o_add_start = start_q;
  assign o_add_a     = a_q;
  assign o_add_b     = b_q;
  assign o_add_p     = p_q;

endmodule

// File: tb/tb_modadd_arbiter.sv
// Scoreboard bench for modadd_arbiter with a behavioural latency-programmable adder.
module tb_modadd_arbiter;

  localparam int unsigned W    = 64;
  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] a_bus = '0;
  logic [NREQ*W-1:0] b_bus = '0;
  logic [W-1:0]      p = '0;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [W-1:0]      result;
  logic [1:0]        gid;
  logic              busy, add_start, add_rst_n;
  logic [W-1:0]      add_a, add_b, add_p;
  logic [W-1:0]      add_result = '0;
  logic              add_done = 1'b0;

  modadd_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_a(a_bus), .i_b(b_bus), .i_p(p),
    .o_ack(ack), .o_err(err), .o_result(result), .o_grant_id(gid), .o_busy(busy),
    .o_add_start(add_start), .o_add_rst_n(add_rst_n),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_p(add_p),
    .i_add_result(add_result), .i_add_done(add_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: done after lat started cycles, sticky until its reset.
  int lat = 5;
  bit never_done = 1'b0;
  int acnt = 0;
  always @(posedge clk) begin
    if (!add_rst_n) begin
      acnt <= 0;
      add_done <= 1'b0;
      add_result <= '0;
    end else if (add_start && !add_done && !never_done) begin
      if (acnt == lat - 1) begin
        add_done <= 1'b1;
        add_result <= W'(({1'b0, add_a} + {1'b0, add_b}) % {1'b0, add_p});
      end
      acnt <= acnt + 1;
    end
  end

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct { logic [W-1:0] res; bit err; } exp_t;

  op_t  pend[NREQ][$];
  exp_t expq[NREQ][$];
  int   ack_log[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NREQ; k++) if (expq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic flush();
    for (int k = 0; k < NREQ; k++) begin
      pend[k].delete();
      expq[k].delete();
    end
  endtask

  // Requester k queues an op; its expected response is (a+b) mod p, or 0/err on timeout.
  task automatic submit(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input bit tmo);
    op_t o;
    exp_t e;
    o.a = a;
    o.b = b;
    e.err = tmo;
    e.res = tmo ? '0 : W'(({1'b0, a} + {1'b0, b}) % {1'b0, p});
    pend[k].push_back(o);
    expq[k].push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (!all_empty()) begin
      total++;
      bad++;
      $display("FAIL wait_idle: ops still pending after %0d cycles", budget);
      flush();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (!add_start && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!add_start) begin
      total++;
      bad++;
      $display("FAIL wait_start: no start within %0d cycles", budget);
    end
  endtask

  task automatic chk_order(input string name, input int want[$]);
    bit ok;
    ok = (ack_log.size() == want.size());
    if (ok) for (int i = 0; i < want.size(); i++) if (ack_log[i] != want[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %p expected %p", name, ack_log, want);
    end
  endtask

  // Monitor/driver: checks acks against the scoreboard and drives requester levels.
  int start_cyc = 0;
  int done_cyc = 0;
  bit start_prev = 1'b0;
  bit done_prev = 1'b0;
  bit gap_chk = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (add_start && !start_prev) start_cyc = cyc;
      if (add_done && !done_prev) done_cyc = cyc;
      if (gap_chk) begin
        chk("gap_add_rst_low", W'(add_rst_n), W'(0));
        gap_chk = 1'b0;
      end
      if (ack != '0) begin
        chk("ack_onehot", W'($onehot(ack)), W'(1));
        for (int k = 0; k < NREQ; k++) begin
          if (ack[k]) begin
            ack_log.push_back(k);
            if (expq[k].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_ack: req %0d acked with nothing pending", k);
            end else begin
              e = expq[k].pop_front();
              pend[k].delete(0);
              chk($sformatf("result_req%0d", k), result, e.res);
              chk($sformatf("err_req%0d", k), W'(err), W'(e.err));
              if (e.err) chk("timeout_latency", W'(cyc - start_cyc), W'(TMO + 1));
              else chk("done_to_ack", W'(cyc - done_cyc), W'(1));
            end
          end
        end
        gap_chk = 1'b1;
      end
      start_prev = add_start;
      done_prev = add_done;
      for (int k = 0; k < NREQ; k++) begin
        req[k] = (pend[k].size() != 0);
        if (pend[k].size() != 0) begin
          a_bus[k*W +: W] = pend[k][0].a;
          b_bus[k*W +: W] = pend[k][0].b;
        end
      end
    end else begin
      start_prev = 1'b0;
      done_prev = 1'b0;
      gap_chk = 1'b0;
      req = '0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rc;
    int order[$];
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", W'(ack), W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_result", result, W'(0));
    chk("rst_gid", W'(gid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_start", W'(add_start), W'(0));
    chk("rst_add_rst_n", W'(add_rst_n), W'(0));
    chk("rst_add_a", add_a, W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_add_rst_n", W'(add_rst_n), W'(1));

    // Single op, with request-to-start latency.
    p = 64'hf_ffff_ffff;
    ack_log.delete();
    submit(0, 64'h1_2345_6789, 64'h0, 1'b0);
    @(negedge clk);
    #1;
    rc = cyc;
    wait_start(20);
    chk("req_to_start", W'(cyc - rc), W'(1));
    chk("grant_id0", W'(gid), W'(0));
    chk("busy_issue", W'(busy), W'(1));
    wait_idle(100);
    chk("single_result_held", result, 64'h1_2345_6789);

    // Modular wrap on requester 2.
    p = 64'h100;
    submit(2, 64'hff, 64'h20, 1'b0);
    wait_idle(100);
    chk("wrap_result", result, 64'h1f);
    chk("wrap_gid", W'(gid), W'(2));

    // Bring the pointer back to 0, then four-way contention with 0 holding for two ops.
    submit(3, 64'h1, 64'h2, 1'b0);
    wait_idle(100);
    p = 64'hffff_ffff_ffff_fff1;
    ack_log.delete();
    submit(0, 64'h10, 64'h01, 1'b0);
    submit(1, 64'h20, 64'h02, 1'b0);
    submit(2, 64'h30, 64'h03, 1'b0);
    submit(3, 64'hffff_ffff_ffff_fff0, 64'h04, 1'b0);
    submit(0, 64'h50, 64'h05, 1'b0);
    wait_idle(300);
    order = '{0, 1, 2, 3, 0};
    chk_order("contention_order", order);

    // Fairness: 1 holds for two ops, 3 arrives mid-op.
    ack_log.delete();
    submit(1, 64'h111, 64'h222, 1'b0);
    submit(1, 64'h333, 64'h444, 1'b0);
    @(negedge clk);
    #1;
    wait_start(20);
    submit(3, 64'h555, 64'h666, 1'b0);
    wait_idle(300);
    order = '{1, 3, 1};
    chk_order("fairness_order", order);

    // Watchdog timeout, then a normal op.
    never_done = 1'b1;
    submit(1, 64'h7, 64'h8, 1'b1);
    wait_idle(100);
    never_done = 1'b0;
    submit(2, 64'h9, 64'ha, 1'b0);
    wait_idle(100);
    chk("post_timeout_result", result, 64'h13);

    // Reset mid-operation: pointer returns to 0.
    submit(2, 64'hb, 64'hc, 1'b0);
    @(negedge clk);
    #1;
    wait_start(20);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    flush();
    chk("midrst_ack", W'(ack), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_start", W'(add_start), W'(0));
    chk("midrst_add_rst_n", W'(add_rst_n), W'(0));
    chk("midrst_add_a", add_a, W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ack_log.delete();
    submit(3, 64'hd, 64'he, 1'b0);
    submit(0, 64'hf, 64'h10, 1'b0);
    wait_idle(200);
    order = '{0, 3};
    chk_order("post_reset_order", order);

    // Randomized batches with random modulus and adder latency.
    for (int batch = 0; batch < 4; batch++) begin
      p = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      lat = int'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++) begin
        ra = {$urandom, $urandom} % p;
        rb = {$urandom, $urandom} % p;
        submit(int'($urandom_range(0, NREQ - 1)), ra, rb, 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
      end
      wait_idle(600);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
